// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default widths and exec-unit FSM states.
// Also used by the ALU controller so both sides agree on the 4-bit operation encoding.
package alu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SUB = 4'b0110,
        OP_SRA = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purpose: single-cycle ALU operations (logic, add/sub, compare); shift codes pass A through.
// Latency: purely combinational, no state.
// Backpressure: none; the enclosing exec unit decides when the output is captured.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] diff;
    logic             slt;

    assign diff = src_a - src_b;
    assign slt  = $signed(src_a) < $signed(src_b);

    always_comb begin
        result = '0;
        case (operation)
            OP_AND:  result = src_a & src_b;
            OP_OR:   result = src_a | src_b;
            OP_ADD:  result = src_a + src_b;
            OP_XOR:  result = src_a ^ src_b;
            OP_SUB:  result = diff;
            OP_BEQ:  result = diff;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
            // A zero-step shift is just A; multi-step shifts are stepped by the exec unit.
            OP_SLL, OP_SRL, OP_SRA: result = src_a;
            default: result = '0;
        endcase
    end

    always_comb begin
        zero = (result == '0);
        if (operation == OP_BEQ) begin
            zero = (src_a == src_b);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose: ALU execute stage with a serial one-bit-per-cycle shifter and a registered result.
// Latency: 1 edge for single-cycle ops and zero-length shifts, shamt+1 edges for shifts.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one bubble between ops).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         sh_op_q, sh_op_d;

    logic [WIDTH-1:0]   core_result;
    logic               core_zero;
    logic [WIDTH-1:0]   step_val;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               start_shift;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .result    (core_result),
        .zero      (core_zero)
    );

    assign shamt       = src_b[SHAMT_W-1:0];
    assign accept      = in_valid && in_ready;
    assign start_shift = is_shift(operation) && (shamt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            sh_op_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
            sh_op_q  <= sh_op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // result_q doubles as the shift register while stepping.
    always_comb begin
        step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        if (sh_op_q == OP_SLL) begin
            step_val = {result_q[WIDTH-2:0], 1'b0};
        end else if (sh_op_q == OP_SRL) begin
            step_val = {1'b0, result_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        sh_op_d  = sh_op_q;
        if (state_q == ST_IDLE && accept) begin
            sh_op_d = operation;
            if (start_shift) begin
                result_d = src_a;
                zero_d   = 1'b0;
                cnt_d    = shamt;
            end else begin
                result_d = core_result;
                zero_d   = core_zero;
                cnt_d    = '0;
            end
        end else if (state_q == ST_SHIFT) begin
            result_d = step_val;
            zero_d   = (step_val == '0);
            cnt_d    = cnt_q - SHAMT_W'(1);
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: what the operation means arithmetically, and how many edges it takes.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0110: r = a - b;
            4'b0100: begin r = a << sh; lat = sh + 1; end
            4'b0101: begin r = a >> sh; lat = sh + 1; end
            4'b0111: begin r = 32'($signed(a) >>> sh); lat = sh + 1; end
            4'b1000: r = a - b;
            4'b1100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        z = (op == 4'b1000) ? (a == b) : (r == 32'd0);
    endfunction

    // Drives one request with out_ready=1 and reports what came back; completes the handshake.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic z, output logic rdy_seen);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = op;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        operation = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
        lat       = 1;
        rdy_seen  = 1'b0;
        while (!out_valid && lat < 200) begin
            rdy_seen  = rdy_seen | in_ready;
            @(negedge clk);
            src_a     = $urandom;
            src_b     = $urandom;
            lat++;
        end
        rdy_seen = rdy_seen | in_ready;
        res      = result;
        z        = zero;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = 4'b0000;
        src_a     = 32'd0;
        src_b     = 32'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_tests++;
        if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat; logic [31:0] r; logic z; logic rs;
        issue(4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, lat, r, z, rs);
        n_tests++;
        if (r !== 32'd0 || z !== 1'b1 || lat != 1) begin
            n_fail++; $display("FAIL add_wrap got r=%h z=%b lat=%0d want r=0 z=1 lat=1", r, z, lat);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drop got out_valid=%b want 0", out_valid); end
        issue(4'b0111, 32'h8000_0000, 32'd4, lat, r, z, rs);
        n_tests++;
        if (r !== 32'hF800_0000 || z !== 1'b0 || lat != 5 || rs !== 1'b0) begin
            n_fail++; $display("FAIL sra4 got r=%h z=%b lat=%0d rdy=%b want r=f8000000 z=0 lat=5 rdy=0", r, z, lat, rs);
        end
        issue(4'b1100, 32'hFFFF_FFFF, 32'd1, lat, r, z, rs);
        n_tests++;
        if (r !== 32'd1 || z !== 1'b0) begin n_fail++; $display("FAIL slt_neg got r=%h z=%b want r=1 z=0", r, z); end
        issue(4'b1000, 32'h1234, 32'h1234, lat, r, z, rs);
        n_tests++;
        if (r !== 32'd0 || z !== 1'b1) begin n_fail++; $display("FAIL beq_eq got r=%h z=%b want r=0 z=1", r, z); end
        issue(4'b1111, 32'hDEAD_BEEF, 32'h1, lat, r, z, rs);
        n_tests++;
        if (r !== 32'd0 || z !== 1'b1 || lat != 1) begin
            n_fail++; $display("FAIL undef_op got r=%h z=%b lat=%0d want r=0 z=1 lat=1", r, z, lat);
        end
        issue(4'b0101, 32'hA5A5_0000, 32'h0000_0020, lat, r, z, rs);
        n_tests++;
        if (r !== 32'hA5A5_0000 || z !== 1'b0 || lat != 1) begin
            n_fail++; $display("FAIL shamt0 got r=%h z=%b lat=%0d want r=a5a50000 z=0 lat=1", r, z, lat);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        operation = 4'b0010;
        src_a     = 32'h0000_1000;
        src_b     = 32'h0000_0234;
        @(posedge clk);
        @(negedge clk);
        operation = 4'b0110;
        src_a     = 32'h0;
        src_b     = 32'h0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || result !== 32'h0000_1234 || zero !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got v=%b r=%h z=%b rdy=%b want v=1 r=00001234 z=0 rdy=0",
                         i, out_valid, result, zero, in_ready);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_ghost got v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midshift();
        int lat; logic [31:0] r; logic z; logic rs; logic saw;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operation = 4'b0100;
        src_a     = 32'h0000_0003;
        src_b     = 32'd31;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_now got v=%b r=%h z=%b rdy=%b want v=0 r=0 z=0 rdy=1",
                               out_valid, result, zero, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        n_tests++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_output got out_valid seen=%b want 0", saw); end
        issue(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, r, z, rs);
        n_tests++;
        if (r !== 32'hFF00_FF00 || z !== 1'b0 || lat != 1) begin
            n_fail++; $display("FAIL after_abort got r=%h z=%b lat=%0d want r=ff00ff00 z=0 lat=1", r, z, lat);
        end
    endtask

    task automatic test_random();
        int lat, exp_lat; logic [31:0] r, a, b, exp_r; logic z, exp_z, rs; logic [3:0] op;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
            model(op, a, b, exp_r, exp_z, exp_lat);
            issue(op, a, b, lat, r, z, rs);
            n_tests++;
            if (r !== exp_r || z !== exp_z || lat != exp_lat || rs !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_%0d op=%b a=%h b=%h got r=%h z=%b lat=%0d rdy=%b want r=%h z=%b lat=%0d rdy=0",
                         i, op, a, b, r, z, lat, rs, exp_r, exp_z, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midshift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
